// File: rtl/semafor_faza_ctrl.sv
// Single-approach traffic-light phase controller, token-chained to neighbouring heads, with blinking-yellow maintenance.
// Optional green extension from a vehicle sensor is enabled by defining GREEN_EXT_EN.
module semafor_faza_ctrl #(
  parameter int SEC         = 10000000,
  parameter int CW          = 8,
  parameter int T_RED_MIN   = 1,
  parameter int T_YELLOW    = 2,
  parameter int T_GREEN     = 17,
  parameter int T_BLINK     = 1,
  parameter int T_GREEN_EXT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intretinere,
  input  logic       continuare_in,
`ifdef GREEN_EXT_EN
  input  logic       senzor_auto,
`endif
  output logic       continuare_out,
  output logic       verde,
  output logic       galben,
  output logic       rosu,
  output logic [2:0] stare
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RED_HOLD = 3'd1,
    S_YELLOW   = 3'd2,
    S_GREEN    = 3'd3,
    S_DONE     = 3'd4,
    S_MAINT    = 3'd5
  } state_t;

  localparam int PW = (SEC > 1) ? $clog2(SEC) : 1;
  // A duration of 0 is treated as 1 s so every phase still ends.
  localparam int TR = (T_RED_MIN < 1) ? 1 : T_RED_MIN;
  localparam int TY = (T_YELLOW  < 1) ? 1 : T_YELLOW;
  localparam int TG = (T_GREEN   < 1) ? 1 : T_GREEN;
  localparam int TB = (T_BLINK   < 1) ? 1 : T_BLINK;
  localparam logic [CW-1:0] TR_C  = CW'(TR);
  localparam logic [CW-1:0] TY_C  = CW'(TY);
  localparam logic [CW-1:0] TG_C  = CW'(TG);
  localparam logic [CW-1:0] TB_C  = CW'(TB);
  localparam logic [CW-1:0] TGE_C = CW'(TG + T_GREEN_EXT);
  localparam logic [PW-1:0] PRE_LAST = PW'(SEC - 1);
`ifdef GREEN_EXT_EN
  localparam logic [CW-1:0] TGM1_C = CW'(TG - 1);
  localparam bit            EXT_OK = (TG > 1);
`endif

  state_t        state_reg, state_next;
  logic [PW-1:0] pres_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] green_lim;
  logic          prev_reg;
  logic          ext_used_reg;
  logic          blink_reg;
  logic          done_d_reg;
  logic          rosu_reg, galben_reg, verde_reg, cont_out_reg;
  logic          tick, rise, ext_grant, blink_wrap, state_chg;

  assign tick      = (pres_reg == PRE_LAST);
  assign rise      = continuare_in & ~prev_reg;
  assign cnt_inc   = cnt_reg + 1'b1;
  assign green_lim = ext_used_reg ? TGE_C : TG_C;
  assign state_chg = (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    ext_grant  = 1'b0;
    blink_wrap = (state_reg == S_MAINT) && tick && (cnt_inc >= TB_C);
`ifdef GREEN_EXT_EN
    ext_grant  = EXT_OK && (state_reg == S_GREEN) && tick && senzor_auto &&
                 !ext_used_reg && (cnt_inc == TGM1_C);
`endif
    // Maintenance overrides every other transition, including a same-edge token rise.
    if (intretinere) begin
      state_next = S_MAINT;
    end else begin
      case (state_reg)
        S_IDLE:     if (rise) state_next = S_RED_HOLD;
        S_RED_HOLD: if (tick && cnt_inc >= TR_C) state_next = S_YELLOW;
        S_YELLOW:   if (tick && cnt_inc >= TY_C) state_next = S_GREEN;
        S_GREEN:    if (tick && cnt_inc >= green_lim) state_next = S_DONE;
        S_DONE:     state_next = S_IDLE;
        S_MAINT:    state_next = S_IDLE;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pres_reg     <= '0;
      cnt_reg      <= '0;
      prev_reg     <= 1'b0;
      ext_used_reg <= 1'b0;
      blink_reg    <= 1'b0;
      done_d_reg   <= 1'b0;
      rosu_reg     <= 1'b1;
      galben_reg   <= 1'b0;
      verde_reg    <= 1'b0;
      cont_out_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= continuare_in;
      pres_reg  <= (state_chg || tick) ? '0 : pres_reg + 1'b1;

      if (state_chg || blink_wrap) cnt_reg <= '0;
      else if (tick)               cnt_reg <= cnt_inc;

      if (state_next == S_MAINT && state_reg != S_MAINT) blink_reg <= 1'b1;
      else if (blink_wrap)                               blink_reg <= ~blink_reg;

      if (state_reg == S_IDLE) ext_used_reg <= 1'b0;
      else if (ext_grant)      ext_used_reg <= 1'b1;

      // Lamps trail the state by one clock; the token pulse trails DONE by two.
      rosu_reg     <= (state_reg == S_IDLE) || (state_reg == S_RED_HOLD) || (state_reg == S_DONE);
      galben_reg   <= (state_reg == S_YELLOW) || (state_reg == S_MAINT && blink_reg);
      verde_reg    <= (state_reg == S_GREEN);
      done_d_reg   <= (state_reg == S_DONE);
      cont_out_reg <= done_d_reg && (state_reg == S_IDLE);
    end
  end

  assign rosu           = rosu_reg;
  assign galben         = galben_reg;
  assign verde          = verde_reg;
  assign continuare_out = cont_out_reg;
  assign stare          = state_reg;

endmodule
